pipelined_addsub: RTL and testbench

- Parametrised successor to the fixed-width ripple-carry adders: a WIDTH-bit adder/subtractor split into STAGES ripple-carry slices, with a register stage after each slice.
- Adds a valid/ready handshake with backpressure, signed overflow detection and borrow-in subtraction.
- Sits between operand-issue logic and the ALU result bus wherever a high-clock-rate wide add is needed.

---
 rtl/pipelined_addsub.sv | 172 +++++++++++++++++
 tb/tb_pipelined_addsub.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - WIDTH-bit add/subtract split into STAGES registered ripple-carry slices
//
// Purpose: pipelined adder/subtractor with valid/ready handshake and backpressure.
// Slice k computes bits [k*CHUNK +: CHUNK] from the carry registered by slice k-1.
// The result leaves the last stage register STAGES cycles after it is accepted.
//
// Parameters:
//   WIDTH   operand/result width (multiple of STAGES)
//   STAGES  number of slices / register stages (1..WIDTH)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready = pipeline may advance)
//   a, b, cin, sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid, out_ready result handshake; result held while stalled
//   sum, cout, ovf       result, carry-out (no-borrow on sub), signed overflow
//   zero, neg            result flags, present only with PIPELINED_ADDSUB_FLAGS_EN
//
// Optional feature macro: PIPELINED_ADDSUB_FLAGS_EN

module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers: completed low sum bits, operand bits still to be
    // processed, carry out of the slice and carry into the slice MSB.
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_valid [STAGES];
    logic             r_c     [STAGES];
    logic             r_cm    [STAGES];

    // Next-state values each stage captures when the pipeline advances.
    logic [WIDTH-1:0] n_sum   [STAGES];
    logic [WIDTH-1:0] n_a     [STAGES];
    logic [WIDTH-1:0] n_b     [STAGES];
    logic             n_valid [STAGES];
    logic             n_c     [STAGES];
    logic             n_cm    [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction is a + ~b + 1; a borrow-in removes that +1.
    assign b_eff = sub ? ~b : b;
    assign c0    = cin ^ sub;

    // The whole pipeline moves in lockstep: it stalls only when a result is
    // waiting and the consumer refuses it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic             src_c;
        logic             src_v;
        logic [CHUNK:0]   part;
        int               idx;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        src_c   = 1'b0;
        src_v   = 1'b0;
        part    = '0;
        idx     = 0;
        for (int k = 0; k < STAGES; k++) begin
            // Clamp so stage 0 never indexes below the array even in dead code.
            idx = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                src_a   = a;
                src_b   = b_eff;
                src_sum = '0;
                src_c   = c0;
                src_v   = in_valid;
            end else begin
                src_a   = r_a[idx];
                src_b   = r_b[idx];
                src_sum = r_sum[idx];
                src_c   = r_c[idx];
                src_v   = r_valid[idx];
            end
            part = {1'b0, src_a[k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c};
            n_sum[k]                   = src_sum;
            n_sum[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            n_a[k]                     = src_a;
            n_b[k]                     = src_b;
            n_valid[k]                 = src_v;
            n_c[k]                     = part[CHUNK];
            // Carry into the slice MSB recovered from that bit's sum: s = a ^ b ^ c.
            n_cm[k] = src_a[k*CHUNK + CHUNK - 1] ^ src_b[k*CHUNK + CHUNK - 1]
                    ^ part[CHUNK-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst) begin
                r_sum[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_valid[k] <= 1'b0;
                r_c[k]     <= 1'b0;
                r_cm[k]    <= 1'b0;
            end else if (advance) begin
                r_sum[k]   <= n_sum[k];
                r_a[k]     <= n_a[k];
                r_b[k]     <= n_b[k];
                r_valid[k] <= n_valid[k];
                r_c[k]     <= n_c[k];
                r_cm[k]    <= n_cm[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_c[STAGES-1] ^ r_cm[STAGES-1];

    // Operand copies in the last stage have no consumer.
    logic unused_last_operands;
    assign unused_last_operands = ^{r_a[STAGES-1], r_b[STAGES-1]};

`ifdef PIPELINED_ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_neg;

    // Flags are computed from the final slice's next sum so they land in the
    // same cycle, and hold under the same stall, as the result itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (advance) begin
            r_zero <= (n_sum[STAGES-1] == '0);
            r_neg  <= n_sum[STAGES-1][WIDTH-1];
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub

module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
`ifdef PIPELINED_ADDSUB_FLAGS_EN
        , .zero(zero), .neg(neg)
`endif
    );

    // Parameter sweep instances share one operand bus (truncated per width).
    logic [63:0] sa;
    logic [63:0] sb;
    logic        scin;
    logic        ssub;
    logic        sv;
    logic        sready;
    logic        unused_rdy8, unused_rdy16, unused_rdy64;
    logic        v8, v16, v64;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [63:0] s64;
    logic        c8, c16, c64;
    logic        o8, o16, o64;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    logic        unused_z8, unused_n8, unused_z16, unused_n16, unused_z64, unused_n64;
`endif

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(unused_rdy8),
        .a(sa[7:0]), .b(sb[7:0]), .cin(scin), .sub(ssub),
        .out_valid(v8), .out_ready(sready), .sum(s8), .cout(c8), .ovf(o8)
`ifdef PIPELINED_ADDSUB_FLAGS_EN
        , .zero(unused_z8), .neg(unused_n8)
`endif
    );

    pipelined_addsub #(.WIDTH(16), .STAGES(2)) u16 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(unused_rdy16),
        .a(sa[15:0]), .b(sb[15:0]), .cin(scin), .sub(ssub),
        .out_valid(v16), .out_ready(sready), .sum(s16), .cout(c16), .ovf(o16)
`ifdef PIPELINED_ADDSUB_FLAGS_EN
        , .zero(unused_z16), .neg(unused_n16)
`endif
    );

    pipelined_addsub #(.WIDTH(64), .STAGES(8)) u64 (
        .clk(clk), .rst(rst), .in_valid(sv), .in_ready(unused_rdy64),
        .a(sa), .b(sb), .cin(scin), .sub(ssub),
        .out_valid(v64), .out_ready(sready), .sum(s64), .cout(c64), .ovf(o64)
`ifdef PIPELINED_ADDSUB_FLAGS_EN
        , .zero(unused_z64), .neg(unused_n64)
`endif
    );

    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
    } res_t;

    // Reference: unsigned arithmetic for the carry, sign-extended arithmetic
    // range check for overflow.
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb_);
        res_t               res;
        logic [65:0]        m;
        logic [65:0]        ux;
        logic [65:0]        uy;
        logic [65:0]        u;
        logic signed [65:0] ex;
        logic signed [65:0] ey;
        logic signed [65:0] r;
        logic signed [65:0] maxp;
        logic signed [65:0] minn;
        m    = (66'd1 << w) - 66'd1;
        ux   = {2'b00, x} & m;
        uy   = {2'b00, y} & m;
        ex   = ux;
        ey   = uy;
        if (ux[w-1]) ex = ux | ~m;
        if (uy[w-1]) ey = uy | ~m;
        maxp = (66'sd1 <<< (w - 1)) - 66'sd1;
        minn = -maxp - 66'sd1;
        if (!sb_) begin
            u      = ux + uy + {65'd0, ci};
            res.co = u[w];
            r      = ex + ey + $signed({65'd0, ci});
        end else begin
            u      = uy + {65'd0, ci};
            res.co = (ux >= u);
            r      = ex - ey - $signed({65'd0, ci});
        end
        res.ov = (r > maxp) || (r < minn);
        res.s  = r[63:0] & m[63:0];
        return res;
    endfunction

    task automatic issue(input logic [31:0] xa, input logic [31:0] xb,
                         input logic xc, input logic xs);
        @(negedge clk);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        cin      = xc;
        sub      = xs;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got v=%b s=%h c=%b o=%b r=%b want v=0 s=0 c=0 o=0 r=1",
                     out_valid, sum, cout, ovf, in_ready);
        end
`ifdef PIPELINED_ADDSUB_FLAGS_EN
        checks++;
        if ({zero, neg} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00", zero, neg);
        end
`endif
    endtask

    task automatic test_add;
        logic [31:0] va [2];
        logic [31:0] vs [2];
        logic [1:0]  vf [2];
        va[0] = 32'hFFFF_FFFF; vs[0] = 32'h0000_0000; vf[0] = 2'b10;
        va[1] = 32'h7FFF_FFFF; vs[1] = 32'h8000_0000; vf[1] = 2'b01;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], 32'd1, 1'b0, 1'b0);
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                in_valid = 1'b0;
                checks++;
                if (n < 4) begin
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL add_latency vec%0d cyc%0d got v=%b want v=0", i, n, out_valid);
                    end
                end else if ({out_valid, sum, cout, ovf} !== {1'b1, vs[i], vf[i]}) begin
                    errors++;
                    $display("FAIL add_result vec%0d got v=%b s=%h c=%b o=%b want v=1 s=%h co=%b",
                             i, out_valid, sum, cout, ovf, vs[i], vf[i]);
                end
            end
        end
    endtask

    task automatic test_sub;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vc [4];
        logic [31:0] vs [4];
        logic [1:0]  vf [4];
        va[0] = 32'd5;         vb[0] = 32'd7; vc[0] = 1'b0; vs[0] = 32'hFFFF_FFFE; vf[0] = 2'b00;
        va[1] = 32'h8000_0000; vb[1] = 32'd1; vc[1] = 1'b0; vs[1] = 32'h7FFF_FFFF; vf[1] = 2'b11;
        va[2] = 32'd10;        vb[2] = 32'd3; vc[2] = 1'b1; vs[2] = 32'd6;         vf[2] = 2'b10;
        va[3] = 32'd3;         vb[3] = 32'd3; vc[3] = 1'b0; vs[3] = 32'd0;         vf[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vc[i], 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, vs[i], vf[i]}) begin
                errors++;
                $display("FAIL sub_result vec%0d got v=%b s=%h c=%b o=%b want v=1 s=%h co=%b",
                         i, out_valid, sum, cout, ovf, vs[i], vf[i]);
            end
`ifdef PIPELINED_ADDSUB_FLAGS_EN
            checks++;
            if ({zero, neg} !== {(vs[i] == 32'd0), vs[i][31]}) begin
                errors++;
                $display("FAIL sub_flags vec%0d got zn=%b%b want zn=%b%b",
                         i, zero, neg, (vs[i] == 32'd0), vs[i][31]);
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int   tx;
        int   rx;
        logic stall;
        tx = 0;
        rx = 0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            @(negedge clk);
            stall     = (c >= 6 && c <= 9);
            out_ready = !stall;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (sum !== 32'h1000_0000 + rx * 17) begin
                    errors++;
                    $display("FAIL bp_order idx%0d got %h want %h", rx, sum, 32'h1000_0000 + rx * 17);
                end
                rx++;
            end
            if (stall) begin
                checks++;
                if ({in_ready, out_valid, sum} !== {1'b0, 1'b1, 32'h1000_0000 + rx * 17}) begin
                    errors++;
                    $display("FAIL bp_hold cyc%0d got r=%b v=%b s=%h want r=0 v=1 s=%h",
                             c, in_ready, out_valid, sum, 32'h1000_0000 + rx * 17);
                end
            end
            if (tx < 8) begin
                in_valid = 1'b1;
                a        = 32'h1000_0000 + tx;
                b        = tx << 4;
                cin      = 1'b0;
                sub      = 1'b0;
                if (in_ready) tx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (rx != 8) begin
            errors++;
            $display("FAIL bp_count got %0d want 8", rx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_dup cyc%0d got v=%b want v=0", n, out_valid);
            end
        end
    endtask

    task automatic test_bubbles;
        logic [3:0] pat;
        logic       expv;
        pat       = 4'b0101;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n >= 1) begin
                expv = (n >= 4 && n <= 7) ? pat[n-4] : 1'b0;
                checks++;
                if (out_valid !== expv) begin
                    errors++;
                    $display("FAIL bubble cyc%0d got v=%b want v=%b", n, out_valid, expv);
                end
            end
            in_valid = (n < 4) ? pat[n] : 1'b0;
            a        = 32'd100 + n;
            b        = 32'd1;
            cin      = 1'b0;
            sub      = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'hA000_0000 + n;
            b        = 32'd2;
            cin      = 1'b0;
            sub      = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_state got v=%b s=%h c=%b o=%b r=%b want v=0 s=0 c=0 o=0 r=1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cyc%0d got v=%b want v=0", n, out_valid);
            end
        end
    endtask

    task automatic test_sweep;
        res_t q8  [$];
        res_t q16 [$];
        res_t q64 [$];
        res_t e;
        sready = 1'b1;
        for (int i = 0; i < 1012; i++) begin
            @(negedge clk);
            if (v8) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL sweep8_extra got result want none");
                end else begin
                    e = q8.pop_front();
                    if ({s8, c8, o8} !== {e.s[7:0], e.co, e.ov}) begin
                        errors++;
                        $display("FAIL sweep8 got s=%h c=%b o=%b want s=%h c=%b o=%b",
                                 s8, c8, o8, e.s[7:0], e.co, e.ov);
                    end
                end
            end
            if (v16) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL sweep16_extra got result want none");
                end else begin
                    e = q16.pop_front();
                    if ({s16, c16, o16} !== {e.s[15:0], e.co, e.ov}) begin
                        errors++;
                        $display("FAIL sweep16 got s=%h c=%b o=%b want s=%h c=%b o=%b",
                                 s16, c16, o16, e.s[15:0], e.co, e.ov);
                    end
                end
            end
            if (v64) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++;
                    $display("FAIL sweep64_extra got result want none");
                end else begin
                    e = q64.pop_front();
                    if ({s64, c64, o64} !== {e.s, e.co, e.ov}) begin
                        errors++;
                        $display("FAIL sweep64 got s=%h c=%b o=%b want s=%h c=%b o=%b",
                                 s64, c64, o64, e.s, e.co, e.ov);
                    end
                end
            end
            if (i < 1000) begin
                if (i == 0) begin
                    sa = 64'hFFFF_FFFF_FFFF_FFFF; sb = 64'd1; scin = 1'b0; ssub = 1'b0;
                end else if (i == 1) begin
                    sa = 64'd0; sb = 64'd0; scin = 1'b1; ssub = 1'b1;
                end else begin
                    sa   = {$urandom, $urandom};
                    sb   = {$urandom, $urandom};
                    scin = 1'($urandom_range(0, 1));
                    ssub = 1'($urandom_range(0, 1));
                end
                sv = 1'b1;
                q8.push_back(model(8, sa, sb, scin, ssub));
                q16.push_back(model(16, sa, sb, scin, ssub));
                q64.push_back(model(64, sa, sb, scin, ssub));
            end else begin
                sv = 1'b0;
            end
        end
        checks++;
        if (q8.size() + q16.size() + q64.size() != 0) begin
            errors++;
            $display("FAIL sweep_lost got %0d/%0d/%0d pending want 0/0/0",
                     q8.size(), q16.size(), q64.size());
        end
    endtask

    initial begin
        sv     = 1'b0;
        sready = 1'b1;
        sa     = '0;
        sb     = '0;
        scin   = 1'b0;
        ssub   = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
